// File: rtl/sm_tdm_liveness_monitor.sv
// Per-endpoint liveness tracking for the TDM receive stage: idle watchdog,
// saturating packet counters, sticky timeout flags, irq and a req/ack clear.
module sm_tdm_liveness_monitor #(
  parameter  int unsigned NUM_TDM_ENDPOINTS = 4,
  parameter  int unsigned TIMEOUT_WIDTH     = 16,
  parameter  int unsigned CNT_WIDTH         = 16,
  localparam int unsigned ENDP_WIDTH        = $clog2(NUM_TDM_ENDPOINTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [ENDP_WIDTH-1:0]        rx_src,
  input  logic [NUM_TDM_ENDPOINTS-1:0] ep_enable,
  input  logic [TIMEOUT_WIDTH-1:0]     timeout_cfg,
  input  logic                         clr_req,
  input  logic [NUM_TDM_ENDPOINTS-1:0] clr_mask,
  output logic                         clr_ack,
  input  logic [ENDP_WIDTH-1:0]        rd_sel,
  output logic [CNT_WIDTH-1:0]         rd_cnt,
  output logic [NUM_TDM_ENDPOINTS-1:0] alive,
  output logic [NUM_TDM_ENDPOINTS-1:0] timeout_flag,
  output logic                         irq
);

  localparam int unsigned N = NUM_TDM_ENDPOINTS;

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_WAIT_FIRST,
    ST_ALIVE,
    ST_TIMED_OUT
  } ep_state_e;

  ep_state_e                state_q [N];
  ep_state_e                state_d [N];
  logic [TIMEOUT_WIDTH-1:0] idle_q  [N];
  logic [TIMEOUT_WIDTH-1:0] idle_d  [N];
  logic [CNT_WIDTH-1:0]     cnt_q   [N];
  logic [CNT_WIDTH-1:0]     cnt_d   [N];
  logic [N-1:0]             flag_q, flag_d;
  logic [CNT_WIDTH-1:0]     rd_cnt_q, rd_cnt_d;
  logic                     clr_ack_q, clr_ack_d;
  logic                     irq_q;

  logic                     clr_fire_c;
  logic [N-1:0]             hit_c, inc_c, clr_c, timeout_c;

  // Register bank: endpoint FSMs, watchdogs, counters, flags and readout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= ST_DISABLED;
        idle_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      flag_q    <= '0;
      rd_cnt_q  <= '0;
      clr_ack_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        idle_q[i]  <= idle_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      flag_q    <= flag_d;
      rd_cnt_q  <= rd_cnt_d;
      clr_ack_q <= clr_ack_d;
      irq_q     <= |flag_q;
    end
  end

  // Next-state logic; a timeout on the clear edge overrides the flag clear.
  always_comb begin
    clr_fire_c = clr_req && !clr_ack_q;
    clr_ack_d  = clr_fire_c;
    flag_d     = flag_q;
    hit_c      = '0;
    inc_c      = '0;
    clr_c      = '0;
    timeout_c  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      idle_d[i]  = idle_q[i];
      cnt_d[i]   = cnt_q[i];

      hit_c[i]     = rx_valid && (rx_src == ENDP_WIDTH'(i));
      inc_c[i]     = hit_c[i] && (state_q[i] != ST_DISABLED);
      clr_c[i]     = clr_fire_c && clr_mask[i];
      timeout_c[i] = ep_enable[i] && (state_q[i] == ST_ALIVE) && !hit_c[i] &&
                     (timeout_cfg != '0) &&
                     (idle_q[i] >= (timeout_cfg - TIMEOUT_WIDTH'(1)));

      if (!ep_enable[i]) begin
        state_d[i] = ST_DISABLED;
        idle_d[i]  = '0;
      end else begin
        case (state_q[i])
          ST_DISABLED:   state_d[i] = ST_WAIT_FIRST;
          ST_WAIT_FIRST: if (hit_c[i]) state_d[i] = ST_ALIVE;
          ST_ALIVE:      if (timeout_c[i]) state_d[i] = ST_TIMED_OUT;
          ST_TIMED_OUT:  if (hit_c[i]) state_d[i] = ST_ALIVE;
          default:       state_d[i] = ST_DISABLED;
        endcase
        if (hit_c[i]) begin
          idle_d[i] = '0;
        end else if ((state_q[i] == ST_ALIVE) && (idle_q[i] != '1)) begin
          idle_d[i] = idle_q[i] + TIMEOUT_WIDTH'(1);
        end
      end

      if (clr_c[i]) begin
        cnt_d[i] = inc_c[i] ? CNT_WIDTH'(1) : '0;
      end else if (inc_c[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end

      if (clr_c[i]) flag_d[i] = 1'b0;
      if (timeout_c[i]) flag_d[i] = 1'b1;
    end

    rd_cnt_d = '0;
    if (32'(rd_sel) < N) rd_cnt_d = cnt_d[rd_sel];
  end

  // Alive decode straight from the state registers.
  always_comb begin
    alive = '0;
    for (int unsigned i = 0; i < N; i++) alive[i] = (state_q[i] == ST_ALIVE);
  end

  assign timeout_flag = flag_q;
  assign irq          = irq_q;
  assign clr_ack      = clr_ack_q;
  assign rd_cnt       = rd_cnt_q;

endmodule

// File: tb/tb_sm_tdm_liveness_monitor.sv
// Scoreboard bench: stimulus queues expected snapshots and ack cycles,
// a negedge monitor compares them against the DUT outputs.
module tb_sm_tdm_liveness_monitor;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [1:0] rx_src;
  logic [2:0] ep_enable;
  logic [15:0] timeout_cfg;
  logic       clr_req;
  logic [2:0] clr_mask;
  logic       clr_ack;
  logic [1:0] rd_sel;
  logic [3:0] rd_cnt;
  logic [2:0] alive;
  logic [2:0] timeout_flag;
  logic       irq;

  sm_tdm_liveness_monitor #(
    .NUM_TDM_ENDPOINTS(3),
    .TIMEOUT_WIDTH(16),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_src(rx_src),
    .ep_enable(ep_enable), .timeout_cfg(timeout_cfg), .clr_req(clr_req),
    .clr_mask(clr_mask), .clr_ack(clr_ack), .rd_sel(rd_sel), .rd_cnt(rd_cnt),
    .alive(alive), .timeout_flag(timeout_flag), .irq(irq)
  );

  typedef struct {
    int    cyc;
    string name;
    int    alive;
    int    flag;
    int    irq;
    int    rdc;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // -1 in a field means "not checked".
  task automatic push_exp(input int at, input string nm, input int a, input int f,
                          input int q, input int r);
    exp_t e;
    e.cyc = at; e.name = nm; e.alive = a; e.flag = f; e.irq = q; e.rdc = r;
    exp_q.push_back(e);
  endtask

  task automatic check_field(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: compare scheduled snapshots and every clr_ack pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          if (exp_q[i].alive >= 0) check_field({exp_q[i].name, "_alive"}, int'(alive), exp_q[i].alive);
          if (exp_q[i].flag  >= 0) check_field({exp_q[i].name, "_flag"}, int'(timeout_flag), exp_q[i].flag);
          if (exp_q[i].irq   >= 0) check_field({exp_q[i].name, "_irq"}, int'(irq), exp_q[i].irq);
          if (exp_q[i].rdc   >= 0) check_field({exp_q[i].name, "_rd_cnt"}, int'(rd_cnt), exp_q[i].rdc);
          exp_q.delete(i);
        end
      end
      if (clr_ack) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL clr_ack_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          check_field("clr_ack_cycle", cyc, ack_q.pop_front());
        end
      end
    end
  end

  initial begin
    int b, h, d, e, f, g, p, q, s;
    rst_n = 1'b0; rx_valid = 1'b0; rx_src = '0; ep_enable = '0; timeout_cfg = '0;
    clr_req = 1'b0; clr_mask = '0; rd_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(cyc, "reset", 0, 0, 0, 0);

    // Silent startup must never time out.
    ep_enable = 3'b111; timeout_cfg = 16'd10;
    step(1000);
    push_exp(cyc, "silent_start", 0, 0, 0, -1);

    // Hits on ep1 at 0,10,20 keep it alive; timeout after the last one.
    rd_sel = 2'd1; b = cyc;
    push_exp(b + 1,  "ep1_first_hit", 2, 0, 0, -1);
    push_exp(b + 15, "ep1_mid", 2, 0, 0, -1);
    push_exp(b + 25, "ep1_count3", 2, 0, 0, 3);
    push_exp(b + 30, "ep1_pre_timeout", 2, 0, 0, -1);
    push_exp(b + 31, "ep1_timeout", 0, 2, 0, -1);
    push_exp(b + 32, "ep1_irq", 0, 2, 1, -1);
    for (int r = 0; r < 33; r++) begin
      rx_valid = (r == 0 || r == 10 || r == 20); rx_src = 2'd1;
      step(1);
    end

    // Re-hit revives ep1 with the flag kept, then clear ep1.
    h = cyc;
    rx_valid = 1'b1; rx_src = 2'd1;
    push_exp(h + 1, "ep1_rehit", 2, 2, 1, 4);
    step(1);
    rx_valid = 1'b0;
    step(1);
    d = cyc;
    clr_req = 1'b1; clr_mask = 3'b010;
    ack_q.push_back(d + 1);
    push_exp(d + 1, "clr_ep1", 2, 0, 1, 0);
    push_exp(d + 2, "clr_irq_drop", 2, 0, 0, 0);
    step(1);
    clr_req = 1'b0; timeout_cfg = 16'd0;
    step(2);

    // Saturate ep2, then clear it alongside a hit.
    rd_sel = 2'd2; e = cyc;
    push_exp(e + 20, "ep2_saturate", 6, 0, 0, 15);
    for (int r = 0; r < 20; r++) begin
      rx_valid = 1'b1; rx_src = 2'd2;
      step(1);
    end
    rx_valid = 1'b0;
    step(1);
    f = cyc;
    clr_req = 1'b1; clr_mask = 3'b100; rx_valid = 1'b1; rx_src = 2'd2;
    ack_q.push_back(f + 1);
    push_exp(f + 1, "clr_with_hit", 6, 0, 0, 1);
    step(1);
    clr_req = 1'b0; rx_valid = 1'b0;
    step(1);

    // clr_req held through the ack starts a second clear; empty mask still acks.
    g = cyc;
    clr_req = 1'b1; clr_mask = 3'b000;
    ack_q.push_back(g + 1);
    ack_q.push_back(g + 3);
    step(3);
    clr_req = 1'b0;
    push_exp(g + 4, "mask0_keep", 6, 0, 0, 1);
    step(2);

    // Disabled endpoint and out-of-range source are ignored.
    p = cyc;
    ep_enable = 3'b011;
    push_exp(p + 1, "ep2_disabled", 2, 0, 0, -1);
    step(1);
    for (int r = 0; r < 6; r++) begin
      rx_valid = 1'b1; rx_src = (r % 2 == 0) ? 2'd2 : 2'd3;
      step(1);
    end
    rx_valid = 1'b0;
    push_exp(p + 8, "ignored_hits", 2, 0, 0, 1);
    step(1);
    rd_sel = 2'd3;
    push_exp(p + 10, "rd_sel_oor", 2, 0, 0, 0);
    step(2);
    rd_sel = 2'd0;
    step(1);

    // Watchdog off for a long silence, then shrink the timeout below idle.
    q = cyc;
    rx_valid = 1'b1; rx_src = 2'd0;
    push_exp(q + 1, "ep0_alive", 3, 0, 0, 1);
    step(1);
    rx_valid = 1'b0;
    step(70000);
    s = cyc;
    push_exp(s, "cfg0_no_timeout", 3, 0, 0, 1);
    timeout_cfg = 16'd5;
    push_exp(s + 1, "cfg_shrink_timeout", 0, 3, 0, -1);
    push_exp(s + 2, "cfg_shrink_irq", 0, 3, 1, 1);
    step(3);

    // Reset during a pending clear: no ack, everything back to zero.
    clr_req = 1'b1; clr_mask = 3'b111;
    #2 rst_n = 1'b0;
    step(2);
    clr_req = 1'b0;
    rst_n = 1'b1;
    push_exp(cyc, "reset_mid_clear", 0, 0, 0, 0);
    step(5);

    foreach (exp_q[i]) begin
      checks++; errors++;
      $display("FAIL %s_missed: got none expected check at cycle %0d", exp_q[i].name, exp_q[i].cyc);
    end
    foreach (ack_q[i]) begin
      checks++; errors++;
      $display("FAIL clr_ack_missing: got 0 expected 1 (cycle %0d)", ack_q[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
